// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the shift-add multiply sequencer.
// One iteration retires one multiplier bit, so a full product takes MUL_ITERS steps.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int XLEN_DEF  = 32;
    localparam int MUL_ITERS = XLEN_DEF;

endpackage

// File: rtl/mul_seq_dp.sv
// Shift-add datapath: mcand/mplier/acc registers and the iteration counter; clear > load > step.
// done_o flags the final step (or, with MUL_SEQ_EARLY_EXIT_EN, an exhausted multiplier).
module mul_seq_dp
    import mul_seq_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    output logic [XLEN-1:0] acc_o,
    output logic            done_o
);

    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_iter;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (load_i) begin
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step_i) begin
            // Sum wraps naturally; only the low XLEN bits of the product are kept.
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));
    assign acc_o     = acc_q;

`ifdef MUL_SEQ_EARLY_EXIT_EN
    // Remaining bits above bit 0 all zero: this step is the last one that can add.
    assign done_o = last_iter | (mplier_q[XLEN-1:1] == '0);
`else
    assign done_o = last_iter;
`endif

endmodule

// File: rtl/mul_sequencer.sv
// Iterative MUL sequencer: valid/ready request in, valid/ready result out, busy_o stalls the pipe.
// XLEN-cycle latency (data-dependent with MUL_SEQ_EARLY_EXIT_EN); result held in DONE until taken.
module mul_sequencer
    import mul_seq_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    input  logic            kill_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    state_e state_q, state_d;
    logic   dp_load, dp_step, dp_done;

    always_comb begin
        state_d = state_q;
        dp_load = 1'b0;
        dp_step = 1'b0;
        if (kill_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        dp_load = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    dp_step = 1'b1;
                    if (dp_done) state_d = DONE;
                end
                DONE: begin
                    if (resp_ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Handshake outputs decode the state register only, keeping inputs off output paths.
    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == DONE);
    assign busy_o       = (state_q == RUN) || (state_q == DONE);

    mul_seq_dp #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_dp (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (dp_load),
        .step_i  (dp_step),
        .clear_i (kill_i),
        .data1_i (data1_i),
        .data2_i (data2_i),
        .acc_o   (result_o),
        .done_o  (dp_done)
    );

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative shift-add multiply sequencer that takes the MUL operation off the single-cycle ALU path. It sits beside the ALU in the EX stage. The pipeline control hands it operands through a valid/ready request, and it returns the low XLEN bits of the product through a valid/ready response. While busy, it asserts a stall toward the hazard unit.

## Interface
Parameters:
- XLEN, 32, operand and result width.
- CNT_W, $clog2(XLEN), width of the iteration counter.

Ports:
- clk_i, input, 1, single clock; all state updates on the rising edge.
- rst_i, input, 1, synchronous, active-high reset.
- req_valid_i, input, 1, operands present on data1_i/data2_i.
- req_ready_o, output, 1, sequencer can accept a request.
- data1_i, input, XLEN, multiplicand.
- data2_i, input, XLEN, multiplier.
- kill_i, input, 1, pipeline flush; abort any operation.
- resp_valid_o, output, 1, result_o holds a completed product.
- resp_ready_i, input, 1, consumer takes the result.
- result_o, output, XLEN, low XLEN bits of data1_i*data2_i.
- busy_o, output, 1, stall request; high in RUN and DONE.

## Operation
- States:
  - IDLE: req_ready_o=1.
  - RUN: iterating.
  - DONE: resp_valid_o=1, holding the result.
- Transitions:
  - IDLE: on req_valid_i & req_ready_o & !kill_i, go to RUN. Load mcand=data1_i, mplier=data2_i, acc=0, cnt=0.
  - RUN, each edge:
    - If mplier[0]=1, acc = acc + mcand (mod 2^XLEN).
    - mcand <<= 1; mplier >>= 1 (logical); cnt++.
    - Go to DONE when cnt==XLEN-1 before the increment.
  - DONE: on resp_ready_i, go to IDLE. Otherwise hold; result_o is stable.
- result_o = acc. It is meaningful only while resp_valid_o=1, and is 0 after reset.
- The product is unsigned and truncated. It equals the combinational MUL result for both signed and unsigned operands (low half).
- kill_i has priority in every state: next state is IDLE, and acc/cnt are cleared. In IDLE, kill_i blocks the accept even if req_valid_i=1.
- A request in RUN or DONE is not accepted (req_ready_o=0). The requester holds its operands stable.
- There is no back-to-back accept in the DONE→IDLE cycle. The earliest new accept is the cycle after the response handshake.
- rst_i has priority over kill_i and all handshakes.

## Timing
- Reset values: state=IDLE, req_ready_o=1, resp_valid_o=0, busy_o=0, result_o=0.
- Reset mid-operation: the next edge is IDLE and the partial result is discarded. No resp_valid_o is produced for the aborted request.
- Latency (macro off): resp_valid_o rises exactly XLEN cycles after the accept edge, i.e. 32 cycles for XLEN=32, independent of the operands.
- Throughput: one product per XLEN+2 cycles with resp_ready_i tied high.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- busy_o rises the cycle after accept and falls the cycle after the response handshake.

## Configuration
- MUL_SEQ_EARLY_EXIT_EN:
  - Defined: in RUN, also go to DONE when the shifted mplier becomes 0. Latency = max(1, index of the highest set bit of data2_i + 1) cycles. data2_i=0 completes in 1 cycle with result 0.
  - Undefined: fixed XLEN-cycle latency; no mplier-zero compare is synthesized.
  - The result value is identical in both builds.

## Structure
- Shared package mul_seq_pkg:
  - state enum {IDLE, RUN, DONE}.
  - XLEN default constant.
  - Iteration-count constant.
- One sub-module, mul_seq_dp: mcand/mplier/acc registers, adder, shifters, and cnt. It has load/step/clear controls and a done flag.
- The top module holds the FSM and handshake logic only.

## Test plan
- Basic: data1_i=3, data2_i=5, resp_ready_i=1 → resp_valid_o 32 cycles after accept, result_o=15, busy_o high throughout.
- Wrap and sign: 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001. 0xFFFFFFFE (-2) × 3 → 0xFFFFFFFA.
- Backpressure: resp_ready_i=0 for 10 cycles after DONE. result_o and resp_valid_o stay stable, and req_ready_o=0 until the handshake.
- Kill: kill_i pulsed at RUN cycle 12 → IDLE next edge, no resp_valid_o. A following 7×9 returns 63.
- Reset mid-run: rst_i high in RUN cycle 5 → all outputs at their reset values next edge. A following 2×2 returns 4.
- With MUL_SEQ_EARLY_EXIT_EN: 7×1 → result 7 one cycle after accept. 1×0x80000000 → result 0x80000000 after 32 cycles.
